poly_note_tracker: RTL

- Parametrised polyphonic successor to the single-note keyboard mapper.
- Consumes the PS/2 set-2 scancode byte stream: make codes, F0 break prefix, E0 extended prefix.
- Tracks up to NUM_VOICES simultaneously held note keys and assigns each to a voice slot.
- Presents per-voice notes, an active mask, a one-cycle note event, and a last-note-priority mono output for the synth voices downstream.

---
 rtl/poly_note_tracker.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/poly_note_tracker.sv
// ============================================================================
// Module : poly_note_tracker
// Tracks held PS/2 set-2 note keys across NUM_VOICES voice slots with a
// last-note-priority mono output. Optional macro POLY_NOTE_TRACKER_STEAL_EN
// makes a full voice pool steal its oldest voice instead of dropping the make.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module poly_note_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_KEYS   = 8,
    parameter int NOTE_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   keycode,
    input  logic                         keycode_valid,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NOTE_W-1:0]            mono_note,
    output logic                         evt_valid,
    output logic                         evt_on,
    output logic [NOTE_W-1:0]            evt_note,
    output logic [2:0]                   evt_voice,
    output logic                         overflow
);

    localparam int              AGE_W     = 3;
    localparam logic [AGE_W-1:0] c_AGE_MAX = AGE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t r_state, w_state_n;

    logic [NOTE_W-1:0]     r_note   [NUM_VOICES];
    logic [AGE_W-1:0]      r_age    [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active;
    logic [NOTE_W-1:0]     w_note_n [NUM_VOICES];
    logic [AGE_W-1:0]      w_age_n  [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_active_n;

    logic              r_evt_valid, r_evt_on, r_overflow;
    logic [NOTE_W-1:0] r_evt_note;
    logic [2:0]        r_evt_voice;
    logic              w_evt_valid_n, w_evt_on_n, w_overflow_n;
    logic [NOTE_W-1:0] w_evt_note_n;
    logic [2:0]        w_evt_voice_n;

    logic [NOTE_W-1:0] w_key;
    logic              w_make, w_break;
    logic              w_held_hit, w_free_hit, w_do_alloc;
    int                w_held_idx, w_free_idx, w_old_idx, w_slot;
    logic [AGE_W-1:0]  w_held_age, w_old_age;
    logic [NOTE_W-1:0] w_mono;

    // Position in the key map, 1-based; codes beyond NUM_KEYS are not notes.
    function automatic logic [NOTE_W-1:0] f_key_note(input logic [7:0] code);
        int idx;
        case (code)
            8'h16:   idx = 1;
            8'h1E:   idx = 2;
            8'h26:   idx = 3;
            8'h25:   idx = 4;
            8'h2E:   idx = 5;
            8'h36:   idx = 6;
            8'h3D:   idx = 7;
            8'h3E:   idx = 8;
            default: idx = 0;
        endcase
        if (idx > NUM_KEYS) idx = 0;
        return NOTE_W'(idx);
    endfunction

    assign w_key = f_key_note(keycode);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_make    = 1'b0;
        w_break   = 1'b0;
        if (keycode_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (keycode == 8'hF0)      w_state_n = S_BRK;
                    else if (keycode == 8'hE0) w_state_n = S_EXT;
                    else if (w_key != '0)      w_make    = 1'b1;
                end
                S_BRK: begin
                    if (keycode != 8'hF0) begin
                        w_state_n = S_IDLE;
                        w_break   = (w_key != '0);
                    end
                end
                S_EXT:     w_state_n = (keycode == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: w_state_n = S_IDLE;
                default:   w_state_n = S_IDLE;
            endcase
        end
    end

    // Descending scans so the lowest matching index wins.
    always_comb begin
        w_held_hit = 1'b0;
        w_held_idx = 0;
        w_held_age = '0;
        w_free_hit = 1'b0;
        w_free_idx = 0;
        w_old_idx  = NUM_VOICES - 1;
        w_old_age  = '0;
        w_mono     = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_active[i] && (r_note[i] == w_key)) begin
                w_held_hit = 1'b1;
                w_held_idx = i;
                w_held_age = r_age[i];
            end
            if (!r_active[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = i;
            end
            if (r_age[i] >= w_old_age) begin
                w_old_age = r_age[i];
                w_old_idx = i;
            end
            if (r_active[i] && (r_age[i] == '0)) w_mono = r_note[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_note_n[i] = r_note[i];
            w_age_n[i]  = r_age[i];
        end
        w_active_n    = r_active;
        w_evt_valid_n = 1'b0;
        w_evt_on_n    = r_evt_on;
        w_evt_note_n  = r_evt_note;
        w_evt_voice_n = r_evt_voice;
        w_overflow_n  = 1'b0;
        w_do_alloc    = 1'b0;
        w_slot        = 0;

        if (w_make && !w_held_hit) begin
            if (w_free_hit) begin
                w_do_alloc = 1'b1;
                w_slot     = w_free_idx;
            end else begin
`ifdef POLY_NOTE_TRACKER_STEAL_EN
                w_do_alloc = 1'b1;
                w_slot     = w_old_idx;
`else
                w_overflow_n = 1'b1;
`endif
            end
        end

        if (w_do_alloc) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i == w_slot) begin
                    w_note_n[i]   = w_key;
                    w_age_n[i]    = '0;
                    w_active_n[i] = 1'b1;
                end else if (r_active[i] && (r_age[i] != c_AGE_MAX)) begin
                    w_age_n[i] = r_age[i] + 1'b1;
                end
            end
            w_evt_valid_n = 1'b1;
            w_evt_on_n    = 1'b1;
            w_evt_note_n  = w_key;
            w_evt_voice_n = 3'(w_slot);
        end else if (w_break && w_held_hit) begin
            // Older voices step down so ages remain a dense 0..k-1 ranking.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i == w_held_idx) begin
                    w_note_n[i]   = '0;
                    w_age_n[i]    = '0;
                    w_active_n[i] = 1'b0;
                end else if (r_active[i] && (r_age[i] > w_held_age)) begin
                    w_age_n[i] = r_age[i] - 1'b1;
                end
            end
            w_evt_valid_n = 1'b1;
            w_evt_on_n    = 1'b0;
            w_evt_note_n  = w_key;
            w_evt_voice_n = 3'(w_held_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_age[i]  <= '0;
            end
            r_active    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_on    <= 1'b0;
            r_evt_note  <= '0;
            r_evt_voice <= '0;
            r_overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= w_note_n[i];
                r_age[i]  <= w_age_n[i];
            end
            r_active    <= w_active_n;
            r_evt_valid <= w_evt_valid_n;
            r_evt_on    <= w_evt_on_n;
            r_evt_note  <= w_evt_note_n;
            r_evt_voice <= w_evt_voice_n;
            r_overflow  <= w_overflow_n;
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
            assign voice_note[g*NOTE_W +: NOTE_W] = r_note[g];
        end
    endgenerate

    assign voice_active = r_active;
    assign mono_note    = w_mono;
    assign evt_valid    = r_evt_valid;
    assign evt_on       = r_evt_on;
    assign evt_note     = r_evt_note;
    assign evt_voice    = r_evt_voice;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire
